// File: rtl/pe_ws_dbuf.sv
// -----------------------------------------------------------------------------
// pe_ws_dbuf -- weight-stationary systolic processing element with a
// double-buffered weight.
//
// A shadow weight register is daisy-chained north->south for preload (w_in ->
// shadow -> w_out) and committed to the active weight by w_swap. Because every
// operation captures its weight at issue, a swap never disturbs work already
// in flight. Activations travel east through a fixed delay line. Partial sums
// travel south through a MAC pipeline that is MAC_LAT registers deep.
//
// Optional build macro:
//   PE_WS_SAT_EN  defined   -> saturating accumulate with sticky sat_flag
//                 undefined -> two's-complement wrap, sat_flag tied low
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset (clears all state incl. weights)
//   flush     synchronous clear of a-delay line, MAC pipeline and outputs;
//             weights are kept (sat_flag is also cleared when saturating)
//   a_in      activation from west (signed A_W)
//   b_in      partial sum from north (signed ACC_W)
//   v_in      a_in/b_in valid
//   w_in      weight from the north shadow chain
//   w_load    shift w_in into the shadow register
//   w_swap    commit shadow to the active weight
//   a_out     activation to east, a_in delayed by A_DLY cycles
//   b_out     b_in + a_in*w, MAC_LAT cycles after capture; 0 when not valid
//   v_out     b_out valid
//   w_out     shadow register, feeds the south tile's w_in
//   sat_flag  sticky overflow indicator
// -----------------------------------------------------------------------------
module pe_ws_dbuf #(
    parameter int A_W     = 8,
    parameter int W_W     = 8,
    parameter int ACC_W   = 22,
    parameter int MAC_LAT = 2,
    parameter int A_DLY   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic signed [A_W-1:0]   a_in,
    input  logic signed [ACC_W-1:0] b_in,
    input  logic                    v_in,
    input  logic signed [W_W-1:0]   w_in,
    input  logic                    w_load,
    input  logic                    w_swap,
    output logic signed [A_W-1:0]   a_out,
    output logic signed [ACC_W-1:0] b_out,
    output logic                    v_out,
    output logic signed [W_W-1:0]   w_out,
    output logic                    sat_flag
);

    localparam int PROD_W = A_W + W_W;
    // Result registers after the operand stage; with MAC_LAT==1 the single
    // register holds the finished sum directly.
    localparam int RES_D  = (MAC_LAT > 1) ? MAC_LAT - 1 : 1;

    // ------------------------------------------------------------------
    // Weights: shadow chain plus active register. The swap reads the
    // shadow value as it stands before any same-cycle load.
    // ------------------------------------------------------------------
    logic signed [W_W-1:0] shadow_reg;
    logic signed [W_W-1:0] active_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
            active_reg <= '0;
        end else begin
            if (w_load) shadow_reg <= w_in;
            if (w_swap) active_reg <= shadow_reg;
        end
    end

    assign w_out = shadow_reg;

    // ------------------------------------------------------------------
    // Activation delay line (no valid gating).
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < A_DLY; gi++) begin : g_a_dly
            logic signed [A_W-1:0] a_dly_reg;
            logic signed [A_W-1:0] a_dly_next;
            if (gi == 0) begin : g_head
                assign a_dly_next = a_in;
            end else begin : g_tail
                assign a_dly_next = g_a_dly[gi-1].a_dly_reg;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     a_dly_reg <= '0;
                else if (flush) a_dly_reg <= '0;
                else            a_dly_reg <= a_dly_next;
            end
        end
    endgenerate

    assign a_out = g_a_dly[A_DLY-1].a_dly_reg;

    // ------------------------------------------------------------------
    // Operand stage. Invalid cycles load zeros so a bubble propagates as a
    // zero result rather than holding stale data.
    // ------------------------------------------------------------------
    logic signed [A_W-1:0]   op_a;
    logic signed [ACC_W-1:0] op_b;
    logic signed [W_W-1:0]   op_w;
    logic                    op_v;

    generate
        if (MAC_LAT == 1) begin : g_direct
            assign op_a = a_in;
            assign op_b = b_in;
            assign op_w = active_reg;
            assign op_v = v_in;
        end else begin : g_capture
            logic signed [A_W-1:0]   cap_a_reg;
            logic signed [ACC_W-1:0] cap_b_reg;
            logic signed [W_W-1:0]   cap_w_reg;
            logic                    cap_v_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cap_a_reg <= '0;
                    cap_b_reg <= '0;
                    cap_w_reg <= '0;
                    cap_v_reg <= 1'b0;
                end else if (flush || !v_in) begin
                    cap_a_reg <= '0;
                    cap_b_reg <= '0;
                    cap_w_reg <= '0;
                    cap_v_reg <= 1'b0;
                end else begin
                    cap_a_reg <= a_in;
                    cap_b_reg <= b_in;
                    cap_w_reg <= active_reg;   // pre-swap weight
                    cap_v_reg <= 1'b1;
                end
            end

            assign op_a = cap_a_reg;
            assign op_b = cap_b_reg;
            assign op_w = cap_w_reg;
            assign op_v = cap_v_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Multiply-accumulate.
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum_res;

    assign prod = op_a * op_w;

`ifdef PE_WS_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  sum_sat;

    // One guard bit is enough: both addends fit in ACC_W bits.
    assign sum_wide = (ACC_W+1)'(op_b) + (ACC_W+1)'(prod);
    assign sum_sat  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_res  = !sum_sat         ? sum_wide[ACC_W-1:0] :
                      sum_wide[ACC_W]  ? ACC_MIN : ACC_MAX;
`else
    logic signed [ACC_W-1:0] prod_ext;

    assign prod_ext = ACC_W'(prod);
    assign sum_res  = op_b + prod_ext;
`endif

    // ------------------------------------------------------------------
    // Result pipeline.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < RES_D; gi++) begin : g_res
            logic signed [ACC_W-1:0] res_reg;
            logic signed [ACC_W-1:0] res_next;
            logic                    res_v_reg;
            logic                    res_v_next;
            if (gi == 0) begin : g_head
                assign res_v_next = op_v;
                assign res_next   = op_v ? sum_res : '0;
            end else begin : g_tail
                assign res_v_next = g_res[gi-1].res_v_reg;
                assign res_next   = g_res[gi-1].res_reg;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_reg   <= '0;
                    res_v_reg <= 1'b0;
                end else if (flush) begin
                    res_reg   <= '0;
                    res_v_reg <= 1'b0;
                end else begin
                    res_reg   <= res_next;
                    res_v_reg <= res_v_next;
                end
            end
`ifdef PE_WS_SAT_EN
            // Saturation tag travels with its result so a flushed op
            // never raises the flag.
            logic res_sat_reg;
            logic res_sat_next;
            if (gi == 0) begin : g_sat_head
                assign res_sat_next = op_v & sum_sat;
            end else begin : g_sat_tail
                assign res_sat_next = g_res[gi-1].res_sat_reg;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     res_sat_reg <= 1'b0;
                else if (flush) res_sat_reg <= 1'b0;
                else            res_sat_reg <= res_sat_next;
            end
`endif
        end
    endgenerate

    assign b_out = g_res[RES_D-1].res_reg;
    assign v_out = g_res[RES_D-1].res_v_reg;

    // ------------------------------------------------------------------
    // Sticky overflow flag. It rises in the same cycle the first clamped
    // result appears on b_out, then holds via the register.
    // ------------------------------------------------------------------
`ifdef PE_WS_SAT_EN
    logic sat_flag_reg;
    logic last_sat;

    assign last_sat = g_res[RES_D-1].res_sat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sat_flag_reg <= 1'b0;
        else if (flush)    sat_flag_reg <= 1'b0;
        else if (last_sat) sat_flag_reg <= 1'b1;
    end

    assign sat_flag = sat_flag_reg | last_sat;
`else
    assign sat_flag = 1'b0;
`endif

endmodule
